nios_cpu_mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the Nios CPU datapath. It accepts a multiply request, drives operand halves into the existing three-product 16×16 multiply cell, and consumes the cell's partial products p1/p2/p3. It then assembles either the low 32 bits (MUL) or the high 32 bits (MULXUU/MULXSU/MULXSS) of the 64-bit product and returns the result over a valid/ready handshake. It sits between the execute-stage operand mux and the multiply cell, with its result feeding M-stage writeback.

---
 rtl/nios_mul_pkg.sv | 44 ++++
 rtl/nios_mul_combine.sv | 42 ++++
 rtl/nios_cpu_mul_seq.sv | 162 ++++++++++++++++
 tb/tb_nios_cpu_mul_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_mul_pkg.sv
// rtl/nios_mul_pkg.sv - shared encodings and helpers for the Nios multiply sequencer
//
// Contents:
//   OP_*          2-bit multiply opcode encoding as presented on in_op
//   CELL_LAT_*    legal range of the multiply-cell latency parameter
//   state_t       sequencer FSM state encoding
//   assemble_lo64 folds the three pass-A partial products into the low 49 bits
package nios_mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'd0;
    localparam logic [1:0] OP_MULXUU = 2'd1;
    localparam logic [1:0] OP_MULXSU = 2'd2;
    localparam logic [1:0] OP_MULXSS = 2'd3;

    localparam int CELL_LAT_MIN = 1;
    localparam int CELL_LAT_MAX = 4;

    // Wide enough to hold CELL_LAT_MAX-1 wait cycles.
    localparam int LAT_CNT_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PASS_A,
        ST_WAIT_A,
        ST_CAP_A,
        ST_PASS_B,
        ST_WAIT_B,
        ST_CAP_B,
        ST_DONE
    } state_t;

    // lo64 = p1 + ((p2 + p3) << 16). The middle sum needs 33 bits and the
    // shifted total fits in 49 bits for any 16x16 partial products.
    function automatic logic [48:0] assemble_lo64(
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] p3
    );
        logic [32:0] mid;
        mid = {1'b0, p2} + {1'b0, p3};
        return {17'h0, p1} + {mid, 16'h0};
    endfunction

endpackage

// File: rtl/nios_mul_combine.sv
// rtl/nios_mul_combine.sv - high-word assembly and signed correction for MULX ops
//
// Ports:
//   lo64_hi  in  17  bits [48:32] of the registered pass-A sum
//   p1       in  32  pass-B product a_hi * b_hi
//   op       in  2   opcode (selects the sign corrections)
//   a, b     in  32  original operands
//   hi       out 32  upper word of the 64-bit product for the selected signedness
module nios_mul_combine
    import nios_mul_pkg::*;
(
    input  logic [16:0] lo64_hi,
    input  logic [31:0] p1,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi
);

    logic [31:0] hu;
    logic [31:0] corr_a;
    logic [31:0] corr_b;

    // The carry out of the pass-A sum sits in bit 48, so all 17 upper bits
    // contribute to the unsigned high word.
    assign hu = {15'h0, lo64_hi} + p1;

    // Reinterpreting a negative operand as signed subtracts 2^32 times the
    // other operand, i.e. subtracts that operand from the high word.
    assign corr_a = a[31] ? b : 32'h0;
    assign corr_b = b[31] ? a : 32'h0;

    always_comb begin
        hi = hu;
        case (op)
            OP_MULXSU: hi = hu - corr_a;
            OP_MULXSS: hi = hu - corr_a - corr_b;
            default:   hi = hu;
        endcase
    end

endmodule

// File: rtl/nios_cpu_mul_seq.sv
// rtl/nios_cpu_mul_seq.sv - multi-cycle multiply sequencer driving the 16x16 three-product cell
//
// Parameters:
//   CELL_LAT   cycles from a cell_en pulse to valid cell_p* (1..4)
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     request handshake; in_ready high only in IDLE
//   in_op, in_a, in_b     opcode and operands
//   cell_src1/cell_src2   operands to the multiply cell, held outside PASS states
//   cell_en               one-cycle enable pulse per cell pass
//   cell_p1/p2/p3         lo*lo, a_lo*b_hi, a_hi*b_lo products from the cell
//   out_valid/out_ready   result handshake; result held until accepted
//   out_result            low word (MUL) or high word (MULX*) of the product
module nios_cpu_mul_seq
    import nios_mul_pkg::*;
#(
    parameter int CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result
);

    if (CELL_LAT < CELL_LAT_MIN || CELL_LAT > CELL_LAT_MAX) begin : g_lat_range
        $error("nios_cpu_mul_seq: CELL_LAT out of range");
    end

    // Number of WAIT cycles between a PASS and its CAP.
    localparam logic [LAT_CNT_W-1:0] WAIT_CYCLES = LAT_CNT_W'(CELL_LAT - 1);

    state_t                 state;
    state_t                 state_next;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic [1:0]             op_r;
    logic [31:0]            a_r;
    logic [31:0]            b_r;
    logic [48:0]            lo64_r;
    logic [31:0]            result_r;
    logic [31:0]            src1_r;
    logic [31:0]            src2_r;
    logic [48:0]            lo64_next;
    logic [31:0]            hi;

    assign lo64_next = assemble_lo64(cell_p1, cell_p2, cell_p3);

    nios_mul_combine u_combine (
        .lo64_hi (lo64_r[48:32]),
        .p1      (cell_p1),
        .op      (op_r),
        .a       (a_r),
        .b       (b_r),
        .hi      (hi)
    );

    // Next-state and Moore outputs. All outputs decode the state register
    // only, so there is no combinational path from in_valid or out_ready.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        cell_en    = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_PASS_A;
            end
            ST_PASS_A: begin
                cell_en    = 1'b1;
                state_next = (CELL_LAT == 1) ? ST_CAP_A : ST_WAIT_A;
            end
            ST_WAIT_A: begin
                if (lat_cnt == LAT_CNT_W'(1)) state_next = ST_CAP_A;
            end
            ST_CAP_A: begin
                state_next = (op_r == OP_MUL) ? ST_DONE : ST_PASS_B;
            end
            ST_PASS_B: begin
                cell_en    = 1'b1;
                state_next = (CELL_LAT == 1) ? ST_CAP_B : ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (lat_cnt == LAT_CNT_W'(1)) state_next = ST_CAP_B;
            end
            ST_CAP_B: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            op_r     <= 2'd0;
            a_r      <= 32'h0;
            b_r      <= 32'h0;
            lo64_r   <= 49'h0;
            result_r <= 32'h0;
            src1_r   <= 32'h0;
            src2_r   <= 32'h0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_r   <= in_op;
                        a_r    <= in_a;
                        b_r    <= in_b;
                        // Cell sources are loaded on the edge entering a PASS
                        // state so they are already stable while cell_en is high.
                        src1_r <= in_a;
                        src2_r <= in_b;
                    end
                end
                ST_PASS_A, ST_PASS_B: begin
                    lat_cnt <= WAIT_CYCLES;
                end
                ST_WAIT_A, ST_WAIT_B: begin
                    lat_cnt <= lat_cnt - LAT_CNT_W'(1);
                end
                ST_CAP_A: begin
                    lo64_r <= lo64_next;
                    if (op_r != OP_MUL) begin
                        // Pass B computes only a_hi * b_hi on the lo*lo product.
                        src1_r <= {16'h0, a_r[31:16]};
                        src2_r <= {16'h0, b_r[31:16]};
                    end
                end
                ST_CAP_B: begin
                    result_r <= hi;
                end
                default: begin
                end
            endcase
        end
    end

    assign cell_src1  = src1_r;
    assign cell_src2  = src2_r;
    assign out_result = (op_r == OP_MUL) ? lo64_r[31:0] : result_r;

endmodule

// File: tb/tb_nios_cpu_mul_seq.sv
// tb/tb_nios_cpu_mul_seq.sv - directed bench for nios_cpu_mul_seq at CELL_LAT 1 and 3
module tb_nios_cpu_mul_seq;

    localparam logic [1:0] MUL    = 2'd0;
    localparam logic [1:0] MULXUU = 2'd1;
    localparam logic [1:0] MULXSU = 2'd2;
    localparam logic [1:0] MULXSS = 2'd3;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;

    // Index 0: CELL_LAT=1 instance, index 1: CELL_LAT=3 instance.
    logic        in_ready  [2];
    logic        cell_en   [2];
    logic        out_valid [2];
    logic [31:0] cell_src1 [2];
    logic [31:0] cell_src2 [2];
    logic [31:0] cell_p1   [2];
    logic [31:0] cell_p2   [2];
    logic [31:0] cell_p3   [2];
    logic [31:0] out_result[2];

    int n_cmp;
    int n_err;
    int en_cnt[2];

    nios_cpu_mul_seq #(.CELL_LAT(1)) dut_l1 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready[0]),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .cell_src1  (cell_src1[0]),
        .cell_src2  (cell_src2[0]),
        .cell_en    (cell_en[0]),
        .cell_p1    (cell_p1[0]),
        .cell_p2    (cell_p2[0]),
        .cell_p3    (cell_p3[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready),
        .out_result (out_result[0])
    );

    nios_cpu_mul_seq #(.CELL_LAT(3)) dut_l3 (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready[1]),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .cell_src1  (cell_src1[1]),
        .cell_src2  (cell_src2[1]),
        .cell_en    (cell_en[1]),
        .cell_p1    (cell_p1[1]),
        .cell_p2    (cell_p2[1]),
        .cell_p3    (cell_p3[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready),
        .out_result (out_result[1])
    );

    function automatic logic [31:0] prod16(input logic [15:0] x, input logic [15:0] y);
        return {16'h0, x} * {16'h0, y};
    endfunction

    // Multiply-cell models: first stage loads on cell_en, later stages shift.
    logic [31:0] q1_l1, q2_l1, q3_l1;
    logic [31:0] q1_l3[3], q2_l3[3], q3_l3[3];

    always @(posedge clk) begin
        if (cell_en[0]) begin
            q1_l1 <= prod16(cell_src1[0][15:0],  cell_src2[0][15:0]);
            q2_l1 <= prod16(cell_src1[0][15:0],  cell_src2[0][31:16]);
            q3_l1 <= prod16(cell_src1[0][31:16], cell_src2[0][15:0]);
        end
        if (cell_en[1]) begin
            q1_l3[0] <= prod16(cell_src1[1][15:0],  cell_src2[1][15:0]);
            q2_l3[0] <= prod16(cell_src1[1][15:0],  cell_src2[1][31:16]);
            q3_l3[0] <= prod16(cell_src1[1][31:16], cell_src2[1][15:0]);
        end
        for (int k = 1; k < 3; k++) begin
            q1_l3[k] <= q1_l3[k-1];
            q2_l3[k] <= q2_l3[k-1];
            q3_l3[k] <= q3_l3[k-1];
        end
        if (cell_en[0]) en_cnt[0] <= en_cnt[0] + 1;
        if (cell_en[1]) en_cnt[1] <= en_cnt[1] + 1;
    end

    assign cell_p1[0] = q1_l1;
    assign cell_p2[0] = q2_l1;
    assign cell_p3[0] = q3_l1;
    assign cell_p1[1] = q1_l3[2];
    assign cell_p2[1] = q2_l3[2];
    assign cell_p3[1] = q3_l3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issues one request to both instances and checks result, latency
    // (edges counted from the accept edge inclusive) and cell_en pulses.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int          lat[2];
        logic [31:0] res[2];
        bit          seen[2];
        int          en0[2];
        int          n;
        int          cl[2];
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq({tag, " in_ready L1"}, {31'h0, in_ready[0]}, 32'd1);
        expect_eq({tag, " in_ready L3"}, {31'h0, in_ready[1]}, 32'd1);
        en0[0] = en_cnt[0];
        en0[1] = en_cnt[1];
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        seen = '{0, 0};
        lat  = '{0, 0};
        res  = '{32'h0, 32'h0};
        while (!(seen[0] && seen[1]) && n < 40) begin
            for (int i = 0; i < 2; i++) begin
                if (!seen[i] && out_valid[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = n;
                    res[i]  = out_result[i];
                end
            end
            if (!(seen[0] && seen[1])) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        cl[0] = 1;
        cl[1] = 3;
        for (int i = 0; i < 2; i++) begin
            expect_eq($sformatf("%s result L%0d", tag, cl[i]), res[i], exp);
            expect_eq($sformatf("%s latency L%0d", tag, cl[i]), lat[i],
                      (op == MUL) ? cl[i] + 2 : 2 * cl[i] + 3);
            expect_eq($sformatf("%s cell_en pulses L%0d", tag, cl[i]), en_cnt[i] - en0[i],
                      (op == MUL) ? 32'd1 : 32'd2);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        in_op = MUL;
        in_a = 32'h0;
        in_b = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            expect_eq($sformatf("reset in_ready %0d", i),   {31'h0, in_ready[i]},  32'd1);
            expect_eq($sformatf("reset out_valid %0d", i),  {31'h0, out_valid[i]}, 32'd0);
            expect_eq($sformatf("reset cell_en %0d", i),    {31'h0, cell_en[i]},   32'd0);
            expect_eq($sformatf("reset cell_src1 %0d", i),  cell_src1[i],          32'h0);
            expect_eq($sformatf("reset cell_src2 %0d", i),  cell_src2[i],          32'h0);
            expect_eq($sformatf("reset out_result %0d", i), out_result[i],         32'h0);
        end

        run_op("mul_small",   MUL,    32'h0001_0003, 32'h0002_0005, 32'h000B_000F);
        run_op("mulxuu_ff",   MULXUU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulxss_ff",   MULXSS, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulxss_min",  MULXSS, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000);
        run_op("mulxsu_ff",   MULXSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulxuu_mix",  MULXUU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E);

        // Backpressure: 0x12345678 * 0x10 = 0x1_2345_6780.
        repeat (2) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_op = MUL; in_a = 32'h1234_5678; in_b = 32'h0000_0010; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_eq("bp first valid", {31'h0, out_valid[0]}, 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            expect_eq($sformatf("bp valid c%0d", c),    {31'h0, out_valid[0]}, 32'd1);
            expect_eq($sformatf("bp result c%0d", c),   out_result[0],         32'h2345_6780);
            expect_eq($sformatf("bp in_ready c%0d", c), {31'h0, in_ready[0]},  32'd0);
            expect_eq($sformatf("bp cell_en c%0d", c),  {31'h0, cell_en[0]},   32'd0);
        end
        expect_eq("bp result L3", out_result[1], 32'h2345_6780);
        expect_eq("bp valid L3",  {31'h0, out_valid[1]}, 32'd1);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("bp release valid",    {31'h0, out_valid[0]}, 32'd0);
        expect_eq("bp release in_ready", {31'h0, in_ready[0]},  32'd1);

        // Reset while the CELL_LAT=3 instance sits in WAIT_B (accept + 6 edges).
        repeat (2) @(posedge clk);
        @(negedge clk);
        in_op = MULXUU; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        expect_eq("abort pre cell_en",  {31'h0, cell_en[1]},   32'd0);
        expect_eq("abort pre in_ready", {31'h0, in_ready[1]},  32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        expect_eq("abort in_ready",   {31'h0, in_ready[1]},  32'd1);
        expect_eq("abort out_valid",  {31'h0, out_valid[1]}, 32'd0);
        expect_eq("abort out_result", out_result[1],         32'h0);
        expect_eq("abort cell_src1",  cell_src1[1],          32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_op("mul_7x6", MUL, 32'd7, 32'd6, 32'h0000_002A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
